// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the irq_ctrl interrupt controller.
// Register offsets, widths and the lowest-index priority helper.
package irq_ctrl_pkg;

  localparam logic [3:0] IRQ_MASK = 4'h0;
  localparam logic [3:0] IRQ_MODE = 4'h4;
  localparam logic [3:0] IRQ_PEND = 4'h8;
  localparam logic [3:0] IRQ_ID   = 4'hC;

  localparam int IRQ_ID_VALID = 31;
  localparam int MAX_SRC      = 6;

  typedef logic [MAX_SRC-1:0] src_vec_t;

  function automatic logic [2:0] lowest_idx(
    input src_vec_t v
  );
    logic [2:0] r;
    r = 3'd0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Slave bus plus interrupt lines of irq_ctrl.
// The CPU bridge side is master; the controller is slave.
interface irq_ctrl_if #(
  parameter int N_SRC = 6
);
  logic [N_SRC-1:0] IRQ_I;
  logic [3:0]       ADD_I;
  logic             WE_I;
  logic [31:0]      DAT_I;
  logic [31:0]      DAT_O;
  logic [5:0]       HWINT_O;

  modport master (
    output IRQ_I,
    output ADD_I,
    output WE_I,
    output DAT_I,
    input  DAT_O,
    input  HWINT_O
  );

  modport slave (
    input  IRQ_I,
    input  ADD_I,
    input  WE_I,
    input  DAT_I,
    output DAT_O,
    output HWINT_O
  );
endinterface

// File: rtl/irq_ctrl_src_cell.sv
// One interrupt source: line history and sticky/level pending bit.
// Edge mode: a rise sets, W1C clears, and a rise beats a clear.
module irq_ctrl_src_cell (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  input  logic mode,
  input  logic clr,
  output logic pend
);

  logic irq_q, irq_d;
  logic pend_q, pend_d;
  logic rise;

  always_comb begin
    irq_d  = irq;
    rise   = irq & ~irq_q;
    pend_d = irq;
    if (mode) pend_d = rise | (pend_q & ~clr);
  end

  // Line history is loaded in reset so release sees no false rise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_q  <= irq;
      pend_q <= 1'b0;
    end else begin
      irq_q  <= irq_d;
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: mask, mode, pending, ID registers.
// Drives a registered pending&mask vector to CP0 HWINT.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC = 6
) (
  input logic      clk,
  input logic      reset,
  irq_ctrl_if.slave bus
);

  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] clr;
  src_vec_t         hwint_q, hwint_d;
  src_vec_t         pm;
  logic [31:0]      rdata;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    irq_ctrl_src_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .irq   (bus.IRQ_I[g]),
      .mode  (mode_q[g]),
      .clr   (clr[g]),
      .pend  (pend[g])
    );
  end

  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    clr    = '0;
    rdata  = '0;
    pm     = '0;
    pm[N_SRC-1:0] = pend & mask_q;
    hwint_d = pm;
    unique case (1'b1)
      (bus.ADD_I == IRQ_MASK): begin
        rdata[N_SRC-1:0] = mask_q;
        if (bus.WE_I) mask_d = bus.DAT_I[N_SRC-1:0];
      end
      (bus.ADD_I == IRQ_MODE): begin
        rdata[N_SRC-1:0] = mode_q;
        if (bus.WE_I) mode_d = bus.DAT_I[N_SRC-1:0];
      end
      (bus.ADD_I == IRQ_PEND): begin
        rdata[N_SRC-1:0] = pend;
        if (bus.WE_I) clr = bus.DAT_I[N_SRC-1:0] & mode_q;
      end
      (bus.ADD_I == IRQ_ID): begin
        rdata[IRQ_ID_VALID] = |pm;
        rdata[2:0]          = lowest_idx(pm);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mask_q  <= '0;
      mode_q  <= '0;
      hwint_q <= '0;
    end else begin
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      hwint_q <= hwint_d;
    end
  end

  assign bus.DAT_O   = rdata;
  assign bus.HWINT_O = hwint_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus
// randomized traffic against a cycle-level reference model.
module tb_irq_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  irq_ctrl_if #(.N_SRC(6)) bus ();
  irq_ctrl_if #(.N_SRC(4)) bus4 ();

  irq_ctrl #(.N_SRC(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  irq_ctrl #(.N_SRC(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [5:0] m_mask, m_mode, m_pend, m_prev, m_hw;

  function automatic logic [31:0] m_read(input logic [3:0] a);
    logic [5:0] act;
    act = m_pend & m_mask;
    case (a)
      4'h0: return {26'd0, m_mask};
      4'h4: return {26'd0, m_mode};
      4'h8: return {26'd0, m_pend};
      4'hC: begin
        for (int i = 0; i < 6; i++)
          if (act[i]) return 32'h8000_0000 | 32'(i);
        return 32'd0;
      end
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model with the inputs present at this edge.
  task automatic tick();
    logic [5:0] np;
    logic       w1c;
    if (!reset) begin
      m_mask = 0; m_mode = 0; m_pend = 0; m_hw = 0;
      m_prev = bus.IRQ_I;
    end else begin
      m_hw = m_pend & m_mask;
      w1c = bus.WE_I && bus.ADD_I == 4'h8;
      for (int i = 0; i < 6; i++) begin
        if (m_mode[i])
          np[i] = (bus.IRQ_I[i] && !m_prev[i]) ||
                  (m_pend[i] && !(w1c && bus.DAT_I[i]));
        else
          np[i] = bus.IRQ_I[i];
      end
      if (bus.WE_I && bus.ADD_I == 4'h0) m_mask = bus.DAT_I[5:0];
      if (bus.WE_I && bus.ADD_I == 4'h4) m_mode = bus.DAT_I[5:0];
      m_pend = np;
      m_prev = bus.IRQ_I;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.WE_I  = 1'b1;
    bus.ADD_I = a;
    bus.DAT_I = d;
    tick();
    bus.WE_I  = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    bus.WE_I  = 1'b0;
    bus.ADD_I = a;
    #1;
    d = bus.DAT_O;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    bus.IRQ_I = '0; bus.ADD_I = '0;
    bus.WE_I = 1'b0; bus.DAT_I = '0;
    bus4.IRQ_I = '0; bus4.ADD_I = '0;
    bus4.WE_I = 1'b0; bus4.DAT_I = '0;
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    for (int a = 0; a < 16; a += 4) begin
      rd(4'(a), d);
      total++;
      if (d !== 32'd0) begin
        bad++;
        $display("FAIL reset_reg%0h got=%h exp=0", a, d);
      end
    end
    total++;
    if (bus.HWINT_O !== 6'd0) begin
      bad++;
      $display("FAIL reset_hwint got=%h exp=0", bus.HWINT_O);
    end
  endtask

  task automatic test_level();
    logic [31:0] d;
    wr(4'h0, 32'h1);
    wr(4'h4, 32'h0);
    bus.IRQ_I = 6'h01;
    tick();
    rd(4'h8, d);
    total++;
    if (d !== 32'h1) begin
      bad++;
      $display("FAIL level_pend got=%h exp=1", d);
    end
    total++;
    if (bus.HWINT_O !== 6'h00) begin
      bad++;
      $display("FAIL level_hw_k got=%h exp=0", bus.HWINT_O);
    end
    tick();
    total++;
    if (bus.HWINT_O !== 6'h01) begin
      bad++;
      $display("FAIL level_hw_k1 got=%h exp=1", bus.HWINT_O);
    end
    bus.IRQ_I = 6'h00;
    tick();
    total++;
    if (bus.HWINT_O !== 6'h01) begin
      bad++;
      $display("FAIL level_drop1 got=%h exp=1", bus.HWINT_O);
    end
    tick();
    total++;
    if (bus.HWINT_O !== 6'h00) begin
      bad++;
      $display("FAIL level_drop2 got=%h exp=0", bus.HWINT_O);
    end
  endtask

  task automatic test_edge();
    logic [31:0] d;
    wr(4'h4, 32'h2);
    wr(4'h0, 32'h2);
    bus.IRQ_I = 6'h02;
    tick();
    bus.IRQ_I = 6'h00;
    tick(); tick();
    rd(4'h8, d);
    total++;
    if (d !== 32'h2) begin
      bad++;
      $display("FAIL edge_sticky got=%h exp=2", d);
    end
    rd(4'hC, d);
    total++;
    if (d !== 32'h8000_0001) begin
      bad++;
      $display("FAIL edge_id got=%h exp=80000001", d);
    end
    total++;
    if (bus.HWINT_O !== 6'h02) begin
      bad++;
      $display("FAIL edge_hw got=%h exp=2", bus.HWINT_O);
    end
    wr(4'h8, 32'h2);
    rd(4'h8, d);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL edge_w1c got=%h exp=0", d);
    end
    tick();
    total++;
    if (bus.HWINT_O !== 6'h00) begin
      bad++;
      $display("FAIL edge_hw_clr got=%h exp=0", bus.HWINT_O);
    end
  endtask

  task automatic test_set_vs_clear();
    logic [31:0] d;
    bus.IRQ_I = 6'h02;
    tick();
    bus.IRQ_I = 6'h00;
    tick();
    bus.IRQ_I = 6'h02;
    wr(4'h8, 32'h2);
    rd(4'h8, d);
    total++;
    if (d !== 32'h2) begin
      bad++;
      $display("FAIL set_wins got=%h exp=2", d);
    end
    bus.IRQ_I = 6'h00;
    wr(4'h8, 32'h2);
    rd(4'h8, d);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL set_then_clr got=%h exp=0", d);
    end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    wr(4'h0, 32'h0);
    wr(4'h4, 32'h24);
    bus.IRQ_I = 6'h24;
    tick();
    bus.IRQ_I = 6'h00;
    tick();
    wr(4'h0, 32'h20);
    rd(4'hC, d);
    total++;
    if (d !== 32'h8000_0005) begin
      bad++;
      $display("FAIL prio_id5 got=%h exp=80000005", d);
    end
    wr(4'h0, 32'h24);
    rd(4'hC, d);
    total++;
    if (d !== 32'h8000_0002) begin
      bad++;
      $display("FAIL prio_id2 got=%h exp=80000002", d);
    end
    wr(4'h0, 32'h0);
    rd(4'hC, d);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL prio_id0 got=%h exp=0", d);
    end
    tick();
    total++;
    if (bus.HWINT_O !== 6'h00) begin
      bad++;
      $display("FAIL prio_hw0 got=%h exp=0", bus.HWINT_O);
    end
    rd(4'h8, d);
    total++;
    if (d !== 32'h24) begin
      bad++;
      $display("FAIL prio_pend got=%h exp=24", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    wr(4'h4, 32'h3F);
    bus.IRQ_I = 6'h3F;
    tick();
    reset = 1'b0;
    bus.WE_I = 1'b1;
    bus.ADD_I = 4'h0;
    bus.DAT_I = 32'hFFFF_FFFF;
    tick();
    bus.WE_I = 1'b0;
    reset = 1'b1;
    for (int a = 0; a < 16; a += 4) begin
      rd(4'(a), d);
      total++;
      if (d !== 32'd0) begin
        bad++;
        $display("FAIL rmid_reg%0h got=%h exp=0", a, d);
      end
    end
    total++;
    if (bus.HWINT_O !== 6'h00) begin
      bad++;
      $display("FAIL rmid_hw got=%h exp=0", bus.HWINT_O);
    end
    // MODE is level after reset, so held lines re-pend.
    tick();
    rd(4'h8, d);
    total++;
    if (d !== 32'h3F) begin
      bad++;
      $display("FAIL rmid_level got=%h exp=3f", d);
    end
    wr(4'h4, 32'h3F);
    wr(4'h8, 32'h3F);
    tick(); tick();
    rd(4'h8, d);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL rmid_no_edge got=%h exp=0", d);
    end
    total++;
    if (bus.HWINT_O !== 6'h00) begin
      bad++;
      $display("FAIL rmid_hw2 got=%h exp=0", bus.HWINT_O);
    end
    bus.IRQ_I = 6'h00;
    tick();
  endtask

  task automatic test_decode();
    logic [31:0] d;
    wr(4'h4, 32'h15);
    rd(4'h4, d);
    total++;
    if (d !== 32'h15) begin
      bad++;
      $display("FAIL dec_mode got=%h exp=15", d);
    end
    rd(4'h6, d);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL dec_hole got=%h exp=0", d);
    end
    wr(4'h6, 32'hFFFF_FFFF);
    rd(4'h0, d);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL dec_ignore got=%h exp=0", d);
    end
    bus4.WE_I = 1'b1;
    bus4.ADD_I = 4'h0;
    bus4.DAT_I = 32'hFFFF_FFFF;
    tick();
    bus4.WE_I = 1'b0;
    #1;
    total++;
    if (bus4.DAT_O !== 32'hF) begin
      bad++;
      $display("FAIL dec_n4_mask got=%h exp=f", bus4.DAT_O);
    end
    tick();
    total++;
    if (bus4.HWINT_O !== 6'h0) begin
      bad++;
      $display("FAIL dec_n4_hw got=%h exp=0", bus4.HWINT_O);
    end
  endtask

  task automatic test_random();
    logic [31:0] d, e;
    logic [3:0]  a;
    logic [3:0]  addrs [5];
    addrs[0] = 4'h0; addrs[1] = 4'h4; addrs[2] = 4'h8;
    addrs[3] = 4'hC; addrs[4] = 4'h0;
    for (int n = 0; n < 400; n++) begin
      bus.IRQ_I = 6'($urandom);
      reset = ($urandom_range(0, 49) != 0);
      bus.WE_I = ($urandom_range(0, 2) == 0);
      addrs[4] = 4'($urandom);
      bus.ADD_I = addrs[$urandom_range(0, 4)];
      bus.DAT_I = ($urandom_range(0, 3) == 0) ?
                  32'hFFFF_FFFF : $urandom;
      tick();
      reset = 1'b1;
      bus.WE_I = 1'b0;
      total++;
      if (bus.HWINT_O !== m_hw) begin
        bad++;
        $display("FAIL rnd_hw n=%0d got=%h exp=%h",
                 n, bus.HWINT_O, m_hw);
      end
      a = addrs[$urandom_range(0, 4)];
      rd(a, d);
      e = m_read(a);
      total++;
      if (d !== e) begin
        bad++;
        $display("FAIL rnd_rd n=%0d a=%h got=%h exp=%h",
                 n, a, d, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_level();
    test_edge();
    test_set_vs_clear();
    test_priority();
    test_reset_mid();
    test_decode();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
